// File: rtl/attn_job_scheduler_pkg.sv
// Shared types and helpers for the attention-engine job scheduler.
// Holds the FSM state encoding, the debug width, and the round-robin pick function.
package attn_sched_pkg;

  localparam int DBG_STATE_W = 3;
  localparam int RR_MAX      = 32;

  typedef enum logic [DBG_STATE_W-1:0] {
    S_IDLE     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_WAIT     = 3'd2,
    S_ABORT    = 3'd3,
    S_COMPLETE = 3'd4
  } sched_state_e;

  // One-hot grant of the first set request found searching upward from ptr+1,
  // wrapping at n. Vectors are padded to RR_MAX so the function stays width-generic.
  function automatic logic [RR_MAX-1:0] next_rr(input logic [RR_MAX-1:0] req,
                                                input int ptr,
                                                input int n);
    logic [RR_MAX-1:0] gnt;
    logic              found;
    int                idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 1; i <= RR_MAX; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if ((i <= n) && !found && (idx < RR_MAX) && req[idx[4:0]]) begin
        gnt[idx[4:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/attn_job_scheduler_if.sv
// Requester and engine signal bundle between the scheduler (master) and its clients (slave).
// Handshake: req is a level held until the cycle ack pulses for that requester; engine_start
// and engine_abort are one-cycle pulses; engine_done may be a pulse or a level and is only
// honoured while the scheduler is waiting on the engine.
interface attn_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic               resp_err;
  logic [IDX_W-1:0]   grant_idx;
  logic               busy;
  logic               engine_start;
  logic               engine_abort;
  logic               engine_done;

  modport master (
    input  req, engine_done,
    output ack, resp_err, grant_idx, busy, engine_start, engine_abort
  );

  modport slave (
    output req, engine_done,
    input  ack, resp_err, grant_idx, busy, engine_start, engine_abort
  );
endinterface

// File: rtl/attn_job_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first request above the pointer, with wrap.
// Produces a valid flag and the binary index of the chosen requester.
module rr_arbiter
  import attn_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_grant_valid,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic [RR_MAX-1:0] w_req_ext;
  logic [RR_MAX-1:0] w_onehot;
  logic              w_unused_bits;

  assign w_req_ext     = RR_MAX'(i_req);
  assign w_onehot      = next_rr(w_req_ext, int'(i_ptr), NUM_REQ);
  assign w_unused_bits = ^w_onehot;
  assign o_grant_valid = |i_req;

  always_comb begin
    o_grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_onehot[i]) o_grant_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/attn_job_scheduler.sv
// Round-robin job scheduler sharing one self-attention engine among NUM_REQ requesters.
// Performance counters exist only when ATTN_SCHED_PERF_CNT_EN is defined; otherwise tied to 0.
module attn_job_scheduler
  import attn_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TMR_W          = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sched_en,
  attn_sched_if.master           bus,
  output logic [DBG_STATE_W-1:0] fsm_debug_state,
  output logic [TMR_W-1:0]       perf_jobs,
  output logic [TMR_W-1:0]       perf_busy_cycles
);

  localparam logic             WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] WDOG_LAST = WDOG_EN ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

  sched_state_e       r_state;
  sched_state_e       w_state_next;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_busy;
  logic               r_resp_err;
  logic [TMR_W-1:0]   r_timer;
  logic               w_arb_valid;
  logic [IDX_W-1:0]   w_arb_idx;
  logic [NUM_REQ-1:0] w_ack;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req         (bus.req),
    .i_ptr         (r_rr_ptr),
    .o_grant_valid (w_arb_valid),
    .o_grant_idx   (w_arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (sched_en && w_arb_valid) w_state_next = S_LAUNCH;
      S_LAUNCH:   w_state_next = S_WAIT;
      // Done takes priority over an expiring watchdog in the same cycle.
      S_WAIT: begin
        if (bus.engine_done)                       w_state_next = S_COMPLETE;
        else if (WDOG_EN && (r_timer == WDOG_LAST)) w_state_next = S_ABORT;
      end
      S_ABORT:    w_state_next = S_COMPLETE;
      S_COMPLETE: w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_idx <= '0;
      r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
      r_busy      <= 1'b0;
      r_resp_err  <= 1'b0;
      r_timer     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_state_next == S_LAUNCH) begin
            r_grant_idx <= w_arb_idx;
            r_busy      <= 1'b1;
          end
        end
        S_LAUNCH: r_timer <= '0;
        S_WAIT: begin
          if (r_timer != '1)   r_timer    <= r_timer + TMR_W'(1);
          if (bus.engine_done) r_resp_err <= 1'b0;
        end
        S_ABORT: r_resp_err <= 1'b1;
        S_COMPLETE: begin
          r_rr_ptr <= r_grant_idx;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_ack = '0;
    if (r_state == S_COMPLETE) w_ack[r_grant_idx] = 1'b1;
  end

  assign bus.ack          = w_ack;
  assign bus.resp_err     = (r_state == S_COMPLETE) && r_resp_err;
  assign bus.grant_idx    = r_grant_idx;
  assign bus.busy         = r_busy;
  assign bus.engine_start = (r_state == S_LAUNCH);
  assign bus.engine_abort = (r_state == S_ABORT);
  assign fsm_debug_state  = r_state;

`ifdef ATTN_SCHED_PERF_CNT_EN
  logic [TMR_W-1:0] r_perf_jobs;
  logic [TMR_W-1:0] r_perf_busy;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_jobs <= '0;
      r_perf_busy <= '0;
    end else begin
      if ((r_state == S_COMPLETE) && (r_perf_jobs != '1)) r_perf_jobs <= r_perf_jobs + TMR_W'(1);
      if (r_busy && (r_perf_busy != '1))                  r_perf_busy <= r_perf_busy + TMR_W'(1);
    end
  end

  assign perf_jobs        = r_perf_jobs;
  assign perf_busy_cycles = r_perf_busy;
`else
  assign perf_jobs        = '0;
  assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_attn_job_scheduler.sv
// Directed bench for attn_job_scheduler: a driver issues jobs, an engine model answers them,
// and a negedge monitor checks grants and acknowledges against expected queues.
module tb_attn_job_scheduler;
  import attn_sched_pkg::*;

  localparam int NR = 4;
  localparam int TO = 16;
  localparam int TW = 32;
`ifdef ATTN_SCHED_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sched_en = 1'b0;
  logic [2:0]    dbg;
  logic [TW-1:0] perf_jobs;
  logic [TW-1:0] perf_busy;

  attn_sched_if #(.NUM_REQ(NR)) bus();

  attn_job_scheduler #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO),
    .TMR_W          (TW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .sched_en         (sched_en),
    .bus              (bus),
    .fsm_debug_state  (dbg),
    .perf_jobs        (perf_jobs),
    .perf_busy_cycles (perf_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int n_aborts = 0;
  int ack_count = 0;
  int last_start_cyc = -1;
  int last_ack_cyc   = -1;
  int last_abort_cyc = -1;
  int busy_fall_cyc  = -1;
  int done_delay     = -1;
  logic prev_busy = 1'b0;
  logic [1:0] exp_start_q[$];
  logic [4:0] exp_ack_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [1:0] e_idx;
    logic [4:0] e_ack;
    if (!rst) begin
      if (bus.engine_start) begin
        n_starts++;
        last_start_cyc = cyc;
        if (exp_start_q.size() == 0) check("start_unexpected", 64'd1, 64'd0);
        else begin
          e_idx = exp_start_q.pop_front();
          check("start_grant_idx", 64'(bus.grant_idx), 64'(e_idx));
        end
      end
      if (bus.engine_abort) begin
        n_aborts++;
        last_abort_cyc = cyc;
      end
      if (bus.ack != '0) begin
        ack_count++;
        last_ack_cyc = cyc;
        if (exp_ack_q.size() == 0) check("ack_unexpected", 64'd1, 64'd0);
        else begin
          e_ack = exp_ack_q.pop_front();
          check("ack_and_err", 64'({bus.ack, bus.resp_err}), 64'(e_ack));
        end
      end
      if (prev_busy && !bus.busy) busy_fall_cyc = cyc;
    end
    prev_busy = bus.busy;
  end

  // ---------------- requester model: drop req on the edge that samples ack ----------------
  always begin : req_drop
    logic [NR-1:0] a;
    @(negedge clk);
    if (!rst && (bus.ack != '0)) begin
      a = bus.ack;
      @(posedge clk);
      #1 bus.req = bus.req & ~a;
    end
  end

  // ---------------- engine model: pulse done done_delay cycles after start ----------------
  always begin : eng
    int d;
    @(negedge clk);
    if (!rst && bus.engine_start && (done_delay >= 0)) begin
      d = done_delay;
      repeat (d) @(posedge clk);
      #1 bus.engine_done = 1'b1;
      @(posedge clk);
      #1 bus.engine_done = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.engine_done = 1'b0;
    done_delay = -1;
    sched_en = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic expect_job(input logic [1:0] idx, input logic err);
    logic [NR-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    exp_start_q.push_back(idx);
    exp_ack_q.push_back({oh, err});
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int k;
    k = 0;
    while ((ack_count < target) && (k < budget)) begin
      tick(1);
      k++;
    end
    check(name, 64'(ack_count), 64'(target));
    tick(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int t0;
    int base;
    int ab0;
    int st0;
    int k;
    bus.req = '0;
    bus.engine_done = 1'b0;
    sched_en = 1'b1;
    rst = 1'b1;
    tick(3);
    check("reset_outputs", 64'({bus.ack, bus.resp_err, bus.grant_idx, bus.busy,
                               bus.engine_start, bus.engine_abort, dbg}), 64'd0);
    check("reset_perf", 64'({perf_jobs, perf_busy}), 64'd0);
    rst = 1'b0;
    tick(1);

    // single job: start at +1, ack at +7, busy falls at +8
    base = ack_count;
    busy_fall_cyc = -1;
    expect_job(2'd0, 1'b0);
    done_delay = 5;
    t0 = cyc;
    bus.req = 4'b0001;
    wait_acks(base + 1, 40, "single_ack_count");
    check("single_start_cycle", 64'(last_start_cyc - t0), 64'd1);
    check("single_ack_cycle", 64'(last_ack_cyc - t0), 64'd7);
    check("single_busy_fall", 64'(busy_fall_cyc - t0), 64'd8);
    check("single_idle_state", 64'(dbg), 64'(S_IDLE));

    // fairness: all four requesting, served 0,1,2,3
    do_reset();
    base = ack_count;
    done_delay = 2;
    for (int i = 0; i < NR; i++) expect_job(2'(i), 1'b0);
    bus.req = 4'b1111;
    wait_acks(base + 4, 80, "fair_ack_count");
    tick(5);
    check("fair_ack_total", 64'(ack_count), 64'(base + 4));
    check("fair_perf_jobs", 64'(perf_jobs), PERF ? 64'd4 : 64'd0);
    check("fair_perf_busy", 64'(perf_busy), PERF ? 64'd16 : 64'd0);

    // round robin: after 2 is served, 0101 grants 0 then 2
    do_reset();
    base = ack_count;
    done_delay = 3;
    expect_job(2'd2, 1'b0);
    bus.req = 4'b0100;
    wait_acks(base + 1, 40, "rr_first_ack");
    expect_job(2'd0, 1'b0);
    expect_job(2'd2, 1'b0);
    bus.req = 4'b0101;
    wait_acks(base + 3, 60, "rr_pair_acks");

    // watchdog: done never comes
    do_reset();
    base = ack_count;
    ab0 = n_aborts;
    expect_job(2'd1, 1'b1);
    bus.req = 4'b0010;
    wait_acks(base + 1, 60, "wdog_ack_count");
    check("wdog_abort_count", 64'(n_aborts), 64'(ab0 + 1));
    check("wdog_abort_delay", 64'(last_abort_cyc - last_start_cyc), 64'd17);
    check("wdog_ack_after_abort", 64'(last_ack_cyc - last_abort_cyc), 64'd1);

    // watchdog tie: done in the last WAIT cycle wins
    do_reset();
    base = ack_count;
    ab0 = n_aborts;
    done_delay = 16;
    expect_job(2'd0, 1'b0);
    bus.req = 4'b0001;
    wait_acks(base + 1, 60, "tie_ack_count");
    check("tie_no_abort", 64'(n_aborts), 64'(ab0));
    check("tie_ack_delay", 64'(last_ack_cyc - last_start_cyc), 64'd17);

    // gating: no grant while sched_en is low
    do_reset();
    base = ack_count;
    sched_en = 1'b0;
    st0 = n_starts;
    bus.req = 4'b1000;
    tick(20);
    check("gate_no_start", 64'(n_starts), 64'(st0));
    check("gate_not_busy", 64'(bus.busy), 64'd0);
    expect_job(2'd3, 1'b0);
    done_delay = 3;
    sched_en = 1'b1;
    t0 = cyc;
    wait_acks(base + 1, 40, "gate_ack_count");
    check("gate_start_cycle", 64'(last_start_cyc - t0), 64'd1);

    // reset in the middle of WAIT
    do_reset();
    st0 = n_starts;
    exp_start_q.push_back(2'd1);
    bus.req = 4'b0010;
    k = 0;
    while ((n_starts == st0) && (k < 10)) begin
      tick(1);
      k++;
    end
    check("midrst_started", 64'(n_starts), 64'(st0 + 1));
    tick(5);
    check("midrst_in_wait", 64'(dbg), 64'(S_WAIT));
    rst = 1'b1;
    bus.req = '0;
    tick(1);
    check("midrst_outputs", 64'({bus.ack, bus.resp_err, bus.grant_idx, bus.busy,
                                bus.engine_start, bus.engine_abort, dbg}), 64'd0);
    check("midrst_perf", 64'({perf_jobs, perf_busy}), 64'd0);
    rst = 1'b0;
    base = ack_count;
    done_delay = 2;
    for (int i = 0; i < NR; i++) expect_job(2'(i), 1'b0);
    bus.req = 4'b1111;
    wait_acks(base + 4, 80, "midrst_after_acks");

    tick(3);
    check("queues_drained", 64'(exp_start_q.size() + exp_ack_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/attn_job_scheduler.md
Name: attn_job_scheduler

Overview:
- Round-robin scheduler that shares one self-attention engine (QKV → QK → softmax → attn pipeline with a start/done handshake) among NUM_REQ requesters, e.g. heads or batch slots.
- Grants one requester at a time, pulses the engine start, and holds the input/output mux select stable for the whole job.
- Waits for engine done, guarded by a watchdog that aborts hung jobs, then acknowledges the requester with an error flag.

Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- IDX_W, $clog2(NUM_REQ), grant index width
- TIMEOUT_CYCLES, 4096, max WAIT cycles before abort; 0 disables the watchdog
- TMR_W, 32, watchdog and perf counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sched_en  in  1  1 = new grants allowed; an in-flight job always finishes
- req  in  NUM_REQ  level request per requester
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- resp_err  out  1  valid with ack; 1 = job aborted by watchdog
- grant_idx  out  IDX_W  engine mux select
- busy  out  1  job in flight
- engine_start  out  1  one-cycle start pulse to engine
- engine_abort  out  1  one-cycle abort pulse to engine
- engine_done  in  1  engine completion, level or pulse
- fsm_debug_state  out  3  encoded state
- perf_jobs  out  TMR_W  completed job count
- perf_busy_cycles  out  TMR_W  cycles with busy=1

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset state: state=IDLE, all outputs 0, rr_ptr=NUM_REQ-1 so requester 0 has first priority, timer=0, perf counters 0.
- Reset asserted in any state returns the block to the reset state on the next edge.
- States: IDLE=0, LAUNCH=1, WAIT=2, ABORT=3, COMPLETE=4.
- IDLE, when sched_en=1 and req≠0:
  - Pick the first set req bit searching upward from rr_ptr+1, with wrap.
  - Register it into grant_idx, set busy=1, go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH:
  - engine_start=1 for exactly this cycle; timer cleared; go to WAIT.
  - engine_done is ignored in LAUNCH.
- WAIT, timer increments each cycle:
  - engine_done=1 → COMPLETE with resp_err_next=0.
  - Else if TIMEOUT_CYCLES≠0 and timer==TIMEOUT_CYCLES-1 → ABORT.
  - engine_done and timeout in the same cycle: done wins, no error.
- ABORT: engine_abort=1 for one cycle; go to COMPLETE with resp_err_next=1.
- COMPLETE:
  - ack[grant_idx]=1 and resp_err valid for this cycle only.
  - rr_ptr ← grant_idx; perf_jobs increments on both success and error.
  - Go to IDLE; busy drops on entry to IDLE.
- grant_idx is constant from LAUNCH through COMPLETE and keeps its last value in IDLE.
- Requester protocol:
  - req[i] falls on the edge that samples ack[i]=1; a later rise is a new request.
  - Dropping req while granted does not cancel the job.
- Latency: req seen in IDLE at cycle 0 → engine_start at cycle 1 → done seen at cycle d → ack at cycle d+1. Minimum ack at cycle 3.
- Counters saturate at all-ones; no wrap-around.
- sched_en falling mid-job has no effect until the job returns to IDLE.

Optional Feature:
- Macro: ATTN_SCHED_PERF_CNT_EN.
- Defined: perf_jobs and perf_busy_cycles count as described in Behaviour.
- Undefined: both ports are tied to 0 and no counter flops exist. Ports stay present so the interface is identical either way.

Decomposition:
- Package attn_sched_pkg:
  - sched_state_e enum with the encodings above.
  - Localparam for the debug state width (3).
  - Function next_rr(req, ptr) returning a one-hot grant.
- One natural sub-module: rr_arbiter, combinational, taking a request vector and a pointer and returning grant_valid and grant index. The scheduler FSM and counters stay in the top module.

Test Plan (NUM_REQ=4, TIMEOUT_CYCLES=16):
- Single job: after reset, req=0001 at cycle 0 and engine_done at cycle 6 → engine_start at cycle 1, grant_idx=0, ack=0001 with resp_err=0 at cycle 7, busy 1→0 at cycle 8.
- Fairness: req=1111 held, each requester dropping on its ack, done 2 cycles after each start → grant order 0,1,2,3, exactly 4 acks, perf_jobs=4.
- Round-robin: after requester 2 is served, req=0101 → grant 0, then 2 on the next job.
- Watchdog: req=0010 with done never asserted → engine_abort 16 cycles after entering WAIT, then ack=0010 with resp_err=1.
- Watchdog tie: done asserted exactly in the 16th WAIT cycle → ack with resp_err=0 and no engine_abort.
- Gating and reset:
  - sched_en=0 with req=1000 → no engine_start for 20 cycles; sched_en=1 → start one cycle later.
  - Reset asserted mid-WAIT → all outputs 0 next cycle, and the next req=1111 grants requester 0.
